// File: rtl/upc_mon_pkg.sv
// Shared types and defaults for the upc_loop_monitor block.
//   mod_status_t : kernel handshake status as seen by the monitor
//   CNT_W_DEF    : default statistics counter width
package upc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2
  } mod_status_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/upc_loop_monitor_sat_counter.sv
// Saturating up-counter used for every statistic in upc_loop_monitor.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc          : add one (stops at all-ones, never wraps)
//   clr          : clear to zero, wins over inc
//   hold         : freeze the value, wins over clr and inc
//   cnt          : current count
import upc_mon_pkg::*;

module sat_counter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (!hold) begin
      if (clr)
        cnt <= '0;
      else if (inc && !(&cnt))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/upc_loop_monitor.sv
// Status/statistics monitor for one ap_ctrl_chain kernel and its pipelined
// loop. Tracks the block-level handshake and counts transactions, loop
// iterations, loop quits and stall cycles; freezes everything once finish
// has been seen so final statistics can be read at leisure.
// Ports:
//   clock, reset                      : rising-edge clock, sync active-high reset
//   ap_start/ap_ready/ap_done/ap_continue : kernel block handshake
//   cur_state                         : kernel FSM state
//   iter_start_*/iter_end_*/quit_*    : state encoding, block, enable of the
//                                       first stage, last stage and quit point
//   loop_start/ready/done/continue    : loop-level handshake
//   quit_at_end                       : loop quits on the final iteration end
//   finish                            : freeze request (sticky)
//   mod_status, loop_active           : registered status
//   *_cnt, last_latency               : saturating statistics
//   frozen                            : set the cycle after finish
import upc_mon_pkg::*;

module upc_loop_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic [1:0]         mod_status,
  output logic               loop_active,
  output logic [CNT_W-1:0]   trans_start_cnt,
  output logic [CNT_W-1:0]   trans_done_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   quit_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   last_trip_cnt,
  output logic [CNT_W-1:0]   last_latency,
  output logic               frozen
);

  mod_status_t state_q, state_d;
  logic [CNT_W-1:0] trip_cnt, cyc_cnt;
  logic it_s, it_e, qt, quit_hit, start_acc, done_acc, stall;

  // loop_ready/loop_continue carry no statistic of their own
  logic unused_loop_hs;
  assign unused_loop_hs = &{1'b0, loop_ready, loop_continue};

  assign it_s      = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign it_e      = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign quit_hit  = (cur_state == quit_state) && quit_enable && !quit_block;
  assign qt        = loop_active && loop_done && (quit_at_end ? quit_hit : 1'b1);
  assign start_acc = ap_start && ap_ready;
  assign done_acc  = ap_done && ap_continue;
  assign stall     = loop_active && (iter_start_block || iter_end_block || quit_block);

  // Handshake status FSM
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!frozen) begin
      unique case (state_q)
        IDLE:      if (ap_start) state_d = RUN;
        RUN:       if (ap_done) begin
                     if (ap_continue) state_d = start_acc ? RUN : IDLE;
                     else             state_d = DONE_WAIT;
                   end
        DONE_WAIT: if (ap_continue) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign mod_status = state_q;

  // Loop activity, freeze flag and the two captured statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      loop_active   <= 1'b0;
      frozen        <= 1'b0;
      last_trip_cnt <= '0;
      last_latency  <= '0;
    end else begin
      if (finish) frozen <= 1'b1;
      if (!frozen) begin
        // quit wins over a coincident start
        if (qt)                           loop_active <= 1'b0;
        else if (loop_start && !loop_active) loop_active <= 1'b1;

        // include the iteration retiring in the quit cycle itself
        if (qt)
          last_trip_cnt <= (it_e && !(&trip_cnt)) ? trip_cnt + 1'b1 : trip_cnt;

        // only the first ap_done of a transaction ends its latency window;
        // ap_done held through DONE_WAIT does not stretch it
        if (ap_done && state_q == RUN)
          last_latency <= (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_trans_start (.clock(clock), .reset(reset), .inc(start_acc), .clr(1'b0), .hold(frozen), .cnt(trans_start_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_trans_done  (.clock(clock), .reset(reset), .inc(done_acc),  .clr(1'b0), .hold(frozen), .cnt(trans_done_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_iter_start  (.clock(clock), .reset(reset), .inc(it_s),      .clr(1'b0), .hold(frozen), .cnt(iter_start_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_iter_end    (.clock(clock), .reset(reset), .inc(it_e),      .clr(1'b0), .hold(frozen), .cnt(iter_end_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_quit        (.clock(clock), .reset(reset), .inc(qt),        .clr(1'b0), .hold(frozen), .cnt(quit_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_stall       (.clock(clock), .reset(reset), .inc(stall),     .clr(1'b0), .hold(frozen), .cnt(stall_cnt));
  // per-invocation trip count; restarts after each quit
  sat_counter #(.CNT_W(CNT_W)) u_trip        (.clock(clock), .reset(reset), .inc(it_e),      .clr(qt),   .hold(frozen), .cnt(trip_cnt));
  // free-running cycle count since the last start accept
  sat_counter #(.CNT_W(CNT_W)) u_cyc         (.clock(clock), .reset(reset), .inc(1'b1),      .clr(start_acc), .hold(frozen), .cnt(cyc_cnt));

endmodule

// File: tb/tb_upc_loop_monitor.sv
module tb_upc_loop_monitor;

  logic clock = 1'b0;
  logic reset;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;

  logic [1:0]  mod_status;
  logic        loop_active, frozen;
  logic [31:0] trans_start_cnt, trans_done_cnt, iter_start_cnt, iter_end_cnt;
  logic [31:0] quit_cnt, stall_cnt, last_trip_cnt, last_latency;

  logic [1:0]  s_mod_status;
  logic        s_loop_active, s_frozen;
  logic [3:0]  s_trans_start_cnt, s_trans_done_cnt, s_iter_start_cnt, s_iter_end_cnt;
  logic [3:0]  s_quit_cnt, s_stall_cnt, s_last_trip_cnt, s_last_latency;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  upc_loop_monitor #(.STATE_W(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done), .loop_continue(loop_continue),
    .quit_at_end(quit_at_end), .finish(finish),
    .mod_status(mod_status), .loop_active(loop_active),
    .trans_start_cnt(trans_start_cnt), .trans_done_cnt(trans_done_cnt),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .quit_cnt(quit_cnt), .stall_cnt(stall_cnt),
    .last_trip_cnt(last_trip_cnt), .last_latency(last_latency), .frozen(frozen)
  );

  upc_loop_monitor #(.STATE_W(1), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done), .loop_continue(loop_continue),
    .quit_at_end(quit_at_end), .finish(finish),
    .mod_status(s_mod_status), .loop_active(s_loop_active),
    .trans_start_cnt(s_trans_start_cnt), .trans_done_cnt(s_trans_done_cnt),
    .iter_start_cnt(s_iter_start_cnt), .iter_end_cnt(s_iter_end_cnt),
    .quit_cnt(s_quit_cnt), .stall_cnt(s_stall_cnt),
    .last_trip_cnt(s_last_trip_cnt), .last_latency(s_last_latency), .frozen(s_frozen)
  );

  // one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 1'b0; iter_start_state = 1'b0; iter_end_state = 1'b0; quit_state = 1'b0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
    quit_at_end = 0; finish = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    repeat (3) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    // activity during reset must not leak into the statistics
    ap_start = 1; ap_ready = 1; iter_start_enable = 1; iter_end_enable = 1; loop_start = 1;
    repeat (3) tick();
    idle();
    reset = 0;
    checks++; if (mod_status !== 2'd0) begin errors++; $display("FAIL reset_status: got %0d expected 0", mod_status); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got %0b expected 0", frozen); end
    checks++; if (loop_active !== 1'b0) begin errors++; $display("FAIL reset_loop_active: got %0b expected 0", loop_active); end
    checks++;
    if ((trans_start_cnt | trans_done_cnt | iter_start_cnt | iter_end_cnt | quit_cnt |
         stall_cnt | last_trip_cnt | last_latency) !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got ts=%0d td=%0d is=%0d ie=%0d q=%0d st=%0d lt=%0d ll=%0d expected all 0",
               trans_start_cnt, trans_done_cnt, iter_start_cnt, iter_end_cnt, quit_cnt, stall_cnt,
               last_trip_cnt, last_latency);
    end
  endtask

  // one transaction, 4 iterations through a 5-deep pipeline
  task automatic test_single_transaction();
    do_reset();
    idle(); quit_at_end = 1; ap_start = 1; ap_ready = 1; tick();          // c0 accept
    idle(); quit_at_end = 1; loop_start = 1; iter_start_enable = 1; tick(); // c1
    for (int i = 0; i < 3; i++) begin                                      // c2..c4
      idle(); quit_at_end = 1; iter_start_enable = 1; tick();
    end
    checks++; if (mod_status !== 2'd1) begin errors++; $display("FAIL single_run_status: got %0d expected 1", mod_status); end
    checks++; if (loop_active !== 1'b1) begin errors++; $display("FAIL single_loop_active: got %0b expected 1", loop_active); end
    checks++; if (iter_start_cnt !== 32'd4) begin errors++; $display("FAIL single_iter_start: got %0d expected 4", iter_start_cnt); end
    for (int i = 0; i < 3; i++) begin                                      // c5..c7
      idle(); quit_at_end = 1; iter_end_enable = 1; tick();
    end
    idle(); quit_at_end = 1; iter_end_enable = 1; loop_done = 1; quit_enable = 1; tick(); // c8 quit
    checks++; if (iter_end_cnt !== 32'd4) begin errors++; $display("FAIL single_iter_end: got %0d expected 4", iter_end_cnt); end
    checks++; if (quit_cnt !== 32'd1) begin errors++; $display("FAIL single_quit: got %0d expected 1", quit_cnt); end
    checks++; if (last_trip_cnt !== 32'd4) begin errors++; $display("FAIL single_last_trip: got %0d expected 4", last_trip_cnt); end
    checks++; if (loop_active !== 1'b0) begin errors++; $display("FAIL single_loop_inactive: got %0b expected 0", loop_active); end
    idle(); ap_done = 1; ap_continue = 1; tick();                          // c9 done
    idle();
    checks++; if (trans_done_cnt !== 32'd1) begin errors++; $display("FAIL single_trans_done: got %0d expected 1", trans_done_cnt); end
    checks++; if (trans_start_cnt !== 32'd1) begin errors++; $display("FAIL single_trans_start: got %0d expected 1", trans_start_cnt); end
    checks++; if (mod_status !== 2'd0) begin errors++; $display("FAIL single_idle: got %0d expected 0", mod_status); end
    checks++; if (last_latency !== 32'd9) begin errors++; $display("FAIL single_latency: got %0d expected 9", last_latency); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL single_stall: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_done_wait();
    do_reset();
    idle(); ap_start = 1; ap_ready = 1; tick();
    idle(); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); ap_done = 1; ap_continue = 0; tick();
      checks++; if (mod_status !== 2'd2) begin errors++; $display("FAIL done_wait_status[%0d]: got %0d expected 2", i, mod_status); end
      checks++; if (trans_done_cnt !== 32'd0) begin errors++; $display("FAIL done_wait_cnt[%0d]: got %0d expected 0", i, trans_done_cnt); end
    end
    idle(); ap_done = 1; ap_continue = 1; tick();
    idle();
    checks++; if (mod_status !== 2'd0) begin errors++; $display("FAIL done_wait_release: got %0d expected 0", mod_status); end
    checks++; if (trans_done_cnt !== 32'd1) begin errors++; $display("FAIL done_wait_done_cnt: got %0d expected 1", trans_done_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle(); ap_start = 1; ap_ready = 1; tick();
    idle(); tick();
    idle(); tick();
    idle(); ap_done = 1; ap_continue = 1; ap_start = 1; ap_ready = 1; tick();
    checks++; if (mod_status !== 2'd1) begin errors++; $display("FAIL b2b_status: got %0d expected 1", mod_status); end
    checks++; if (trans_start_cnt !== 32'd2) begin errors++; $display("FAIL b2b_start_cnt: got %0d expected 2", trans_start_cnt); end
    checks++; if (trans_done_cnt !== 32'd1) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 1", trans_done_cnt); end
    checks++; if (last_latency !== 32'd3) begin errors++; $display("FAIL b2b_latency1: got %0d expected 3", last_latency); end
    idle(); tick();
    idle(); ap_done = 1; ap_continue = 1; tick();
    idle();
    checks++; if (mod_status !== 2'd0) begin errors++; $display("FAIL b2b_idle: got %0d expected 0", mod_status); end
    checks++; if (trans_done_cnt !== 32'd2) begin errors++; $display("FAIL b2b_done_cnt2: got %0d expected 2", trans_done_cnt); end
    checks++; if (last_latency !== 32'd2) begin errors++; $display("FAIL b2b_latency2: got %0d expected 2", last_latency); end
  endtask

  task automatic test_stall();
    do_reset();
    idle(); loop_start = 1; tick();                                            // c0
    idle(); iter_start_enable = 1; tick();                                     // c1
    idle(); iter_start_enable = 1; iter_end_enable = 1; tick();                // c2
    for (int i = 0; i < 2; i++) begin                                          // c3..c4 stalled
      idle(); iter_start_enable = 1; iter_end_enable = 1;
      iter_start_block = 1; iter_end_block = 1; tick();
    end
    idle(); iter_start_enable = 1; iter_end_enable = 1; tick();                // c5
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d expected 2", stall_cnt); end
    checks++; if (iter_start_cnt !== 32'd3) begin errors++; $display("FAIL stall_iter_start: got %0d expected 3", iter_start_cnt); end
    checks++; if (iter_end_cnt !== 32'd2) begin errors++; $display("FAIL stall_iter_end: got %0d expected 2", iter_end_cnt); end
    idle(); quit_at_end = 0; loop_done = 1; tick();                            // c6 quit
    idle();
    checks++; if (quit_cnt !== 32'd1) begin errors++; $display("FAIL stall_quit: got %0d expected 1", quit_cnt); end
    checks++; if (last_trip_cnt !== 32'd2) begin errors++; $display("FAIL stall_last_trip: got %0d expected 2", last_trip_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      idle(); iter_end_enable = 1; tick();
    end
    checks++; if (s_iter_end_cnt !== 4'd15) begin errors++; $display("FAIL sat_at_max: got %0d expected 15", s_iter_end_cnt); end
    for (int i = 0; i < 2; i++) begin
      idle(); iter_end_enable = 1; tick();
    end
    idle();
    checks++; if (s_iter_end_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", s_iter_end_cnt); end
    checks++; if (iter_end_cnt !== 32'd17) begin errors++; $display("FAIL sat_wide: got %0d expected 17", iter_end_cnt); end
  endtask

  task automatic test_freeze();
    do_reset();
    idle(); ap_start = 1; ap_ready = 1; tick();
    idle(); finish = 1; iter_end_enable = 1; tick();   // still counted, freeze next
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL freeze_flag: got %0b expected 1", frozen); end
    checks++; if (iter_end_cnt !== 32'd1) begin errors++; $display("FAIL freeze_last_count: got %0d expected 1", iter_end_cnt); end
    for (int i = 0; i < 3; i++) begin
      idle(); ap_done = 1; ap_continue = 1; ap_start = 1; ap_ready = 1;
      iter_start_enable = 1; iter_end_enable = 1; loop_start = 1; tick();
    end
    idle(); tick();
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL freeze_sticky: got %0b expected 1", frozen); end
    checks++; if (trans_start_cnt !== 32'd1) begin errors++; $display("FAIL freeze_trans_start: got %0d expected 1", trans_start_cnt); end
    checks++; if (trans_done_cnt !== 32'd0) begin errors++; $display("FAIL freeze_trans_done: got %0d expected 0", trans_done_cnt); end
    checks++; if (iter_start_cnt !== 32'd0) begin errors++; $display("FAIL freeze_iter_start: got %0d expected 0", iter_start_cnt); end
    checks++; if (iter_end_cnt !== 32'd1) begin errors++; $display("FAIL freeze_iter_end: got %0d expected 1", iter_end_cnt); end
    checks++; if (mod_status !== 2'd1) begin errors++; $display("FAIL freeze_status: got %0d expected 1", mod_status); end
    checks++; if (loop_active !== 1'b0) begin errors++; $display("FAIL freeze_loop_active: got %0b expected 0", loop_active); end
    do_reset();
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL freeze_reset_clear: got %0b expected 0", frozen); end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_single_transaction();
    test_done_wait();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
